// File: rtl/shift_ser.sv
// Word-wide parallel-to-serial transmitter with a simultaneous serial-to-parallel
// receiver sharing one shift register; back-to-back words stream with no gap.
module shift_ser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             sin,
  output logic             sout,
  output logic             busy,
  output logic             eos,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pout;
  logic             r_eos;
  logic             r_pout_valid;

  logic [WIDTH-1:0] w_sr_shift;
  logic             w_sout;
  logic             w_final;
  logic             w_load;

  // Next shift-register value: transmit end moves out, sin fills the vacated end.
  always_comb begin
    w_sr_shift = r_sr;
    if (MSB_FIRST) begin
      w_sr_shift = {r_sr[WIDTH-2:0], sin};
    end else begin
      w_sr_shift = {sin, r_sr[WIDTH-1:1]};
    end
  end

  // Serial output: transmit end of sr while shifting, forced low when idle.
  always_comb begin
    w_sout = 1'b0;
    if (r_state == SHIFT) begin
      w_sout = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
    end else begin
      w_sout = 1'b0;
    end
  end

  // The final enabled shift also reopens the load port so words can abut.
  assign w_final  = (r_state == SHIFT) && en && (r_cnt == LAST_CNT);
  assign ld_ready = (r_state == IDLE) || w_final;
  assign w_load   = ld_valid && ld_ready;

  // Control FSM, shift datapath and registered end-of-word outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sr         <= {WIDTH{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_pout       <= {WIDTH{1'b0}};
      r_eos        <= 1'b0;
      r_pout_valid <= 1'b0;
    end else begin
      r_eos        <= w_final;
      r_pout_valid <= w_final;
      if (w_final) begin
        r_pout <= w_sr_shift;
      end
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_sr    <= D;
            r_cnt   <= {CW{1'b0}};
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // A load on the final shift wins for sr/cnt and keeps the FSM shifting.
          if (w_load) begin
            r_sr    <= D;
            r_cnt   <= {CW{1'b0}};
            r_state <= SHIFT;
          end else if (en) begin
            r_sr  <= w_sr_shift;
            r_cnt <= r_cnt + CW'(1);
            if (w_final) begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_sr    <= {WIDTH{1'b0}};
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign sout       = w_sout;
  assign busy       = (r_state == SHIFT);
  assign eos        = r_eos;
  assign pout       = r_pout;
  assign pout_valid = r_pout_valid;

endmodule
